// File: rtl/ipml_fifo_rd_unpack.sv
`timescale 1ns/1ps
// ipml_fifo_rd_unpack
// Read-side stage for the mixed-width FIFO, clocked by rd_clk.
// It drives the FIFO's non-FWFT read port, which has a fixed read latency.
// Wide words are prefetched into a small ring buffer of c_RD_LATENCY+2 entries.
// Each buffered word is then unpacked into c_RATIO narrow beats, LSB slice first,
// and presented as a valid/ready stream.
//
// Ports:
//   rd_clk, rd_rst  clock and reset (reset is asynchronous, active-high)
//   fifo_rd_en      FIFO read enable (also the RAM clock enable)
//   fifo_rd_oce     FIFO output register enable, tied high
//   fifo_rd_data    FIFO read data, valid c_RD_LATENCY cycles after fifo_rd_en
//   fifo_rd_empty   FIFO empty flag
//   flush           synchronous drop of all buffered and in-flight words
//   out_data        current narrow beat
//   out_valid       beat valid
//   out_ready       downstream accept
//   buf_level       number of wide words held in the buffer
//   out_last        (only with IPML_RD_UNPACK_LAST_EN) final beat of a wide word
//
// Optional feature macro: IPML_RD_UNPACK_LAST_EN adds the out_last port.
module ipml_fifo_rd_unpack #(
  parameter int c_IN_DATA_WIDTH  = 32,
  parameter int c_OUT_DATA_WIDTH = 8,
  parameter int c_RD_LATENCY     = 1
) (
  input  logic                              rd_clk,
  input  logic                              rd_rst,
  output logic                              fifo_rd_en,
  output logic                              fifo_rd_oce,
  input  logic [c_IN_DATA_WIDTH-1:0]        fifo_rd_data,
  input  logic                              fifo_rd_empty,
  input  logic                              flush,
  output logic [c_OUT_DATA_WIDTH-1:0]       out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(c_RD_LATENCY+3)-1:0] buf_level
`ifdef IPML_RD_UNPACK_LAST_EN
  ,
  output logic                              out_last
`endif
);

  localparam int c_RATIO     = c_IN_DATA_WIDTH / c_OUT_DATA_WIDTH;
  localparam int c_BUF_DEPTH = c_RD_LATENCY + 2;
  localparam int c_LVL_W     = $clog2(c_BUF_DEPTH + 1);
  localparam int c_PTR_W     = $clog2(c_BUF_DEPTH);
  localparam int c_CNT_W     = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;

  logic [c_LVL_W-1:0]         occ_q, occ_d;
  logic [c_LVL_W-1:0]         discard_q, discard_d;
  logic [c_LVL_W-1:0]         pend_s;
  logic [c_LVL_W:0]           inuse_s;
  logic [c_PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [c_PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [c_CNT_W-1:0]         cnt_q, cnt_d;
  logic [c_RD_LATENCY-1:0]    pipe_q, pipe_d;
  logic [c_IN_DATA_WIDTH-1:0] mem_q [c_BUF_DEPTH];
  logic [c_IN_DATA_WIDTH-1:0] head_s;
  logic                       land_s, keep_s, accept_s, last_s, pop_s;

  // Ring pointer increment.
  // The depth need not be a power of two, so the wrap is explicit.
  function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
    if (p == c_PTR_W'(c_BUF_DEPTH - 1)) begin
      return {c_PTR_W{1'b0}};
    end else begin
      return p + c_PTR_W'(1);
    end
  endfunction

  // Number of reads still travelling through the FIFO's read latency.
  function automatic logic [c_LVL_W-1:0] count_ones(input logic [c_RD_LATENCY-1:0] v);
    logic [c_LVL_W-1:0] n;
    n = {c_LVL_W{1'b0}};
    for (int i = 0; i < c_RD_LATENCY; i++) begin
      n = n + c_LVL_W'(v[i]);
    end
    return n;
  endfunction

  assign fifo_rd_oce = 1'b1;
  assign buf_level   = occ_q;

  // Issue decision and stream-side handshake decode.
  always_comb begin
    pend_s   = count_ones(pipe_q);
    // The oldest pipe stage marks the cycle fifo_rd_data is valid.
    land_s   = pipe_q[c_RD_LATENCY-1];
    // Only registered occupancy is counted, so there is no path from out_ready to fifo_rd_en.
    inuse_s  = {1'b0, occ_q} + {1'b0, pend_s};
    fifo_rd_en = !fifo_rd_empty && !flush && !rd_rst &&
                 (inuse_s < (c_LVL_W + 1)'(c_BUF_DEPTH));
    keep_s   = land_s && (discard_q == {c_LVL_W{1'b0}}) && !flush;
    out_valid = (occ_q != {c_LVL_W{1'b0}});
    head_s   = mem_q[rd_ptr_q];
    out_data = head_s[int'(cnt_q) * c_OUT_DATA_WIDTH +: c_OUT_DATA_WIDTH];
    last_s   = (cnt_q == c_CNT_W'(c_RATIO - 1));
    accept_s = out_valid && out_ready && !flush;
    pop_s    = accept_s && last_s;
  end

`ifdef IPML_RD_UNPACK_LAST_EN
  assign out_last = out_valid && last_s;
`endif

  // Next-state logic for occupancy, pointers, beat index, discard count and in-flight pipe.
  always_comb begin
    pipe_d[0] = fifo_rd_en;
    for (int i = 1; i < c_RD_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    occ_d     = occ_q;
    discard_d = discard_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (flush) begin
      occ_d    = {c_LVL_W{1'b0}};
      wr_ptr_d = {c_PTR_W{1'b0}};
      rd_ptr_d = {c_PTR_W{1'b0}};
      cnt_d    = {c_CNT_W{1'b0}};
      // A word landing in the flush cycle is already dropped here.
      // Only the reads still behind it need counting.
      discard_d = pend_s - c_LVL_W'(land_s);
    end else begin
      if (land_s && (discard_q != {c_LVL_W{1'b0}})) begin
        discard_d = discard_q - c_LVL_W'(1);
      end else begin
        discard_d = discard_q;
      end
      if (keep_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (accept_s) begin
        if (last_s) begin
          cnt_d    = {c_CNT_W{1'b0}};
          rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
          cnt_d    = cnt_q + c_CNT_W'(1);
          rd_ptr_d = rd_ptr_q;
        end
      end else begin
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
      end
      case ({keep_s, pop_s})
        2'b10:   occ_d = occ_q + c_LVL_W'(1);
        2'b01:   occ_d = occ_q - c_LVL_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      occ_q     <= {c_LVL_W{1'b0}};
      discard_q <= {c_LVL_W{1'b0}};
      wr_ptr_q  <= {c_PTR_W{1'b0}};
      rd_ptr_q  <= {c_PTR_W{1'b0}};
      cnt_q     <= {c_CNT_W{1'b0}};
      pipe_q    <= {c_RD_LATENCY{1'b0}};
    end else begin
      occ_q     <= occ_d;
      discard_q <= discard_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      pipe_q    <= pipe_d;
    end
  end

  // Prefetch buffer storage.
  // It holds data only, so it has no reset.
  always_ff @(posedge rd_clk) begin
    if (keep_s) begin
      mem_q[wr_ptr_q] <= fifo_rd_data;
    end
  end

endmodule
